btn_event_gen: RTL and testbench

- Sits directly downstream of the per-button debouncers in the Tetris input path; consumes their clean levels.
- Converts each level into discrete move commands:
  - one command on press;
  - optional auto-repeat while held, after an initial delay (DAS-style).
- Queues at most one pending command per button and hands commands to the game FSM over a valid/ready handshake with fixed priority.

---
 rtl/btn_event_gen_if.sv | 14 +
 rtl/btn_event_gen.sv | 109 ++++++++++
 tb/tb_btn_event_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/btn_event_gen_if.sv
// Command channel from the button event generator to the game FSM.
// master offers cmd_valid/cmd_id, slave answers with cmd_ready.
interface btn_event_gen_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/btn_event_gen.sv
// Debounced button levels -> press/auto-repeat commands, one pending bit per button,
// offered one cycle after the event; stalls hold the lowest pending id, extra events coalesce.
module btn_event_gen #(
  parameter int               N_BTN         = 4,
  parameter int               DELAY_CYCLES  = 25000000,
  parameter int               REPEAT_CYCLES = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b0011,
  parameter int               CNT_W         = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_held,
  output logic             drop_evt,
  btn_event_gen_if.master  cmd
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

  state_t           state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] evt;
  logic [N_BTN-1:0] clr;
  logic [ID_W-1:0]  id_sel;

  // btn_held doubles as the previous-sample register for edge detection
  always_comb begin
    evt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      case (state[i])
        IDLE:    evt[i] = btn_in[i] & ~btn_held[i];
        DELAY:   evt[i] = btn_in[i] & (cnt[i] == DELAY_LAST);
        REPEAT:  evt[i] = btn_in[i] & (cnt[i] == REPEAT_LAST);
        default: evt[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    id_sel = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) id_sel = ID_W'(i);
    end
  end

  assign cmd.cmd_valid = |pending;
  assign cmd.cmd_id    = id_sel;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr[i] = cmd.cmd_valid & cmd.cmd_ready & (id_sel == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      pending  <= '0;
      btn_held <= '0;
      drop_evt <= 1'b0;
    end else begin
      btn_held <= btn_in;
      // a new event wins over a same-cycle accept of the same bit
      pending  <= (pending & ~clr) | evt;
      drop_evt <= |(evt & pending & ~clr);
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          IDLE: begin
            cnt[i] <= '0;
            if (btn_in[i] & ~btn_held[i]) state[i] <= REPEAT_MASK[i] ? DELAY : HOLD;
          end
          DELAY: begin
            if (!btn_in[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DELAY_LAST) begin
              state[i] <= REPEAT;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!btn_in[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == REPEAT_LAST) begin
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            cnt[i] <= '0;
            if (!btn_in[i]) state[i] <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btn_event_gen.sv
// Directed scenarios plus random button/ready traffic, checked against a hold-age model.
module tb_btn_event_gen;
  localparam int N = 4;
  localparam int D = 10;
  localparam int R = 4;
  localparam logic [3:0] MASK = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_held;
  logic       drop_evt;

  btn_event_gen_if #(.N_BTN(N)) cmd_bus ();

  btn_event_gen #(
    .N_BTN(N), .DELAY_CYCLES(D), .REPEAT_CYCLES(R), .REPEAT_MASK(MASK), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_held(btn_held),
    .drop_evt(drop_evt), .cmd(cmd_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: age = edges since the press edge while the button stays down, -1 when up
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic       m_drop;
  int         age [4];
  int         acc_n;
  int         acc_id [$];
  int         drops;

  function automatic int low_id(logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("cmd_valid", 32'(cmd_bus.cmd_valid), 32'(|m_pend));
    check("cmd_id", 32'(cmd_bus.cmd_id), low_id(m_pend));
    check("btn_held", 32'(btn_held), 32'(m_prev));
    check("drop_evt", 32'(drop_evt), 32'(m_drop));
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_drop = 1'b0;
    for (int i = 0; i < 4; i++) age[i] = -1;
  endtask

  task automatic model_step(logic [3:0] b, logic rdy);
    logic [3:0] ev;
    logic [3:0] fire;
    ev   = '0;
    fire = '0;
    if ((|m_pend) && rdy) fire[low_id(m_pend)] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        age[i] = m_prev[i] ? age[i] + 1 : 0;
        ev[i]  = (age[i] == 0) ||
                 (MASK[i] && age[i] >= D && ((age[i] - D) % R) == 0);
      end else begin
        age[i] = -1;
      end
    end
    m_drop = |(ev & m_pend & ~fire);
    m_pend = (m_pend & ~fire) | ev;
    m_prev = b;
  endtask

  // called at a falling edge: drive, predict the next rising edge, then check
  task automatic step(logic [3:0] b, logic rdy);
    btn_in            = b;
    cmd_bus.cmd_ready = rdy;
    if (cmd_bus.cmd_valid && rdy) begin
      acc_n++;
      acc_id.push_back(int'(cmd_bus.cmd_id));
    end
    model_step(b, rdy);
    @(negedge clk);
    check_all();
    if (drop_evt) drops++;
  endtask

  task automatic clear_stats();
    acc_n = 0;
    drops = 0;
    acc_id.delete();
  endtask

  initial begin
    logic [3:0] cur;
    rst               = 1'b1;
    btn_in            = '0;
    cmd_bus.cmd_ready = 1'b0;
    model_reset();
    clear_stats();
    #1 check_all();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;

    // single tap on a non-repeating button
    clear_stats();
    repeat (3) step(4'b0100, 1'b1);
    repeat (5) step(4'b0000, 1'b1);
    check("tap_count", acc_n, 1);
    check("tap_id", acc_id[0], 2);

    // auto-repeat: press, +10, +14, +18, +22, +26
    clear_stats();
    repeat (30) step(4'b0001, 1'b1);
    repeat (10) step(4'b0000, 1'b1);
    check("repeat_count", acc_n, 6);
    for (int k = 0; k < acc_id.size(); k++) check("repeat_id", acc_id[k], 0);

    // release inside the delay window
    clear_stats();
    repeat (7) step(4'b0010, 1'b1);
    repeat (12) step(4'b0000, 1'b1);
    check("reldelay_count", acc_n, 1);
    check("reldelay_id", acc_id[0], 1);

    // simultaneous presses under backpressure
    clear_stats();
    repeat (2) step(4'b1010, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    check("stall_id", 32'(cmd_bus.cmd_id), 1);
    repeat (4) step(4'b0000, 1'b1);
    check("prio_count", acc_n, 2);
    check("prio_first", acc_id[0], 1);
    check("prio_second", acc_id[1], 3);

    // coalescing while stalled
    clear_stats();
    repeat (20) step(4'b0001, 1'b0);
    check("coalesce_drops", drops, 3);
    repeat (4) step(4'b0000, 1'b1);
    check("coalesce_count", acc_n, 1);

    // asynchronous reset in the middle of a hold
    repeat (12) step(4'b0001, 1'b1);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;
    clear_stats();
    repeat (20) step(4'b0001, 1'b1);
    repeat (5) step(4'b0000, 1'b1);
    check("rsthold_count", acc_n, 4);

    // random traffic: slowly changing levels, mostly-ready consumer
    cur = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) cur[i] = ~cur[i];
      step(cur, $urandom_range(0, 3) != 0);
    end
    repeat (8) step(4'b0000, 1'b1);
    check("final_idle", 32'(cmd_bus.cmd_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
